// File: rtl/histo_topk_sel.sv
// Streams one histogram frame, keeps the K largest bins, sums them and flags sum >= thresh.
// Define HISTO_TOPK_SAT_EN to make the peak-sum accumulator saturate instead of wrapping.
module histo_topk_sel #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int K      = 10,
    parameter int SUM_W  = 64,
    localparam int IDX_W = $clog2(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              po_histo_vld,
    input  logic [DATA_W-1:0] po_histo_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [SUM_W-1:0]  thresh,
    input  logic [IDX_W-1:0]  res_idx,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_addr,
    output logic [SUM_W-1:0]  sum,
    output logic              enn,
    output logic              done,
    output logic              busy,
    output logic              drop
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUM, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] slot_val_q  [K];
    logic [DATA_W-1:0] slot_val_d  [K];
    logic [ADDR_W-1:0] slot_addr_q [K];
    logic [ADDR_W-1:0] slot_addr_d [K];
    logic [DATA_W-1:0] bank_val_q  [K];
    logic [DATA_W-1:0] bank_val_d  [K];
    logic [ADDR_W-1:0] bank_addr_q [K];
    logic [ADDR_W-1:0] bank_addr_d [K];
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  acc_q, acc_d, acc_add;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              enn_q, enn_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              take_beat, in_sum, in_done;
    logic [IDX_W-1:0]  min_idx;
    logic [DATA_W-1:0] min_val;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (po_histo_vld)           state_d = S_COLLECT;
            S_COLLECT: if (!po_histo_vld)          state_d = S_SUM;
            S_SUM:     if (cnt_q == IDX_W'(K - 1)) state_d = S_DONE;
            S_DONE:                                state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_sum    = (state_q == S_SUM);
        in_done   = (state_q == S_DONE);
        busy      = in_sum || in_done;
        take_beat = po_histo_vld && !busy;
    end

    // Smallest working slot; strict '<' keeps the lowest index on ties.
    always_comb begin
        min_idx = '0;
        min_val = slot_val_q[0];
        for (int i = 1; i < K; i++) begin
            if (slot_val_q[i] < min_val) begin
                min_val = slot_val_q[i];
                min_idx = IDX_W'(i);
            end
        end
    end

`ifdef HISTO_TOPK_SAT_EN
    logic [SUM_W:0] acc_wide;
    always_comb begin
        acc_wide = {1'b0, acc_q} + {1'b0, SUM_W'(slot_val_q[cnt_q])};
        acc_add  = acc_wide[SUM_W] ? '1 : acc_wide[SUM_W-1:0];
    end
`else
    always_comb acc_add = acc_q + SUM_W'(slot_val_q[cnt_q]);
`endif

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        slot_val_d  = slot_val_q;
        slot_addr_d = slot_addr_q;
        bank_val_d  = bank_val_q;
        bank_addr_d = bank_addr_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        enn_d       = enn_q;
        done_d      = in_done;
        drop_d      = po_histo_vld && busy;

        if (take_beat && (po_histo_data > min_val)) begin
            slot_val_d[min_idx]  = po_histo_data;
            slot_addr_d[min_idx] = rd_addr;
        end

        if ((state_q == S_COLLECT) && !po_histo_vld) cnt_d = '0;

        if (in_sum) begin
            acc_d = acc_add;
            cnt_d = (cnt_q == IDX_W'(K - 1)) ? '0 : cnt_q + 1'b1;
        end

        if (in_done) begin
            bank_val_d  = slot_val_q;
            bank_addr_d = slot_addr_q;
            sum_d       = acc_q;
            enn_d       = (acc_q >= thresh);
            slot_val_d  = '{default: '0};
            slot_addr_d = '{default: '0};
            acc_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot arrays are plain flops and must reset, since an unfilled slot has to read as 0.
            slot_val_q  <= '{default: '0};
            slot_addr_q <= '{default: '0};
            bank_val_q  <= '{default: '0};
            bank_addr_q <= '{default: '0};
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            enn_q       <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            slot_val_q  <= slot_val_d;
            slot_addr_q <= slot_addr_d;
            bank_val_q  <= bank_val_d;
            bank_addr_q <= bank_addr_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            enn_q       <= enn_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    // Readout; indices past K-1 read as zero.
    always_comb begin
        res_data = '0;
        res_addr = '0;
        if ({1'b0, res_idx} < (IDX_W + 1)'(K)) begin
            res_data = bank_val_q[res_idx];
            res_addr = bank_addr_q[res_idx];
        end
    end

    assign sum  = sum_q;
    assign enn  = enn_q;
    assign done = done_q;
    assign drop = drop_q;

endmodule

// File: tb/tb_histo_topk_sel.sv
// Self-checking bench for histo_topk_sel: directed frames plus random frames against a top-K model.
`timescale 1ns/1ps
module tb_histo_topk_sel;
    localparam int K      = 10;
    localparam int IDX_W  = $clog2(K);
    localparam int SUM_W  = 64;
    localparam int SUM34  = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              vld;
    logic [31:0]       data;
    logic [7:0]        addr;
    logic [SUM_W-1:0]  thresh;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       res_data;
    logic [7:0]        res_addr;
    logic [SUM_W-1:0]  sum;
    logic              enn, done, busy, drop;

    logic              vld34;
    logic [31:0]       data34;
    logic [7:0]        addr34;
    logic [SUM34-1:0]  thresh34;
    logic [IDX_W-1:0]  idx34;
    logic [31:0]       res_data34;
    logic [7:0]        res_addr34;
    logic [SUM34-1:0]  sum34;
    logic              enn34, done34, busy34, drop34;

    histo_topk_sel #(.DATA_W(32), .ADDR_W(8), .K(K), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .po_histo_vld(vld), .po_histo_data(data), .rd_addr(addr),
        .thresh(thresh), .res_idx(idx), .res_data(res_data), .res_addr(res_addr),
        .sum(sum), .enn(enn), .done(done), .busy(busy), .drop(drop)
    );

    histo_topk_sel #(.DATA_W(32), .ADDR_W(8), .K(K), .SUM_W(SUM34)) dut34 (
        .clk(clk), .rst(rst), .po_histo_vld(vld34), .po_histo_data(data34), .rd_addr(addr34),
        .thresh(thresh34), .res_idx(idx34), .res_data(res_data34), .res_addr(res_addr34),
        .sum(sum34), .enn(enn34), .done(done34), .busy(busy34), .drop(drop34)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: K slots, each beat replaces the smallest (lowest index on ties) if strictly larger.
    logic [31:0] m_val  [K];
    logic [7:0]  m_addr [K];

    task automatic model_clear();
        for (int i = 0; i < K; i++) begin
            m_val[i]  = '0;
            m_addr[i] = '0;
        end
    endtask

    task automatic model_beat(input logic [31:0] d, input logic [7:0] a);
        int lo = 0;
        for (int i = 1; i < K; i++)
            if (m_val[i] < m_val[lo]) lo = i;
        if (d > m_val[lo]) begin
            m_val[lo]  = d;
            m_addr[lo] = a;
        end
    endtask

    function automatic logic [SUM_W-1:0] model_sum();
        logic [SUM_W-1:0] s = '0;
        for (int i = 0; i < K; i++) s += SUM_W'(m_val[i]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame from IDLE and the closing vld=0 beat; afterwards the FSM is in SUM.
    task automatic send_frame(input logic [31:0] qd[$], input logic [7:0] qa[$]);
        for (int i = 0; i < qd.size(); i++) begin
            vld  = 1'b1;
            data = qd[i];
            addr = qa[i];
            model_beat(qd[i], qa[i]);
            step();
        end
        vld  = 1'b0;
        data = '0;
        addr = '0;
        step();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if ({sum, enn, done, busy, drop} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: sum=%0d enn=%b done=%b busy=%b drop=%b, required all 0",
                     sum, enn, done, busy, drop);
        end
        for (int i = 0; i < K; i++) begin
            idx = IDX_W'(i);
            #1;
            n_tests++;
            if (res_data !== '0 || res_addr !== '0) begin
                n_fail++;
                $display("FAIL reset_bank[%0d]: data=%0d addr=%0d, required 0/0", i, res_data, res_addr);
            end
        end
    endtask

    task automatic test_ramp();
        logic [31:0] qd[$];
        logic [7:0]  qa[$];
        int cyc;
        model_clear();
        thresh = 64'd7000;
        for (int i = 0; i < 256; i++) begin
            qd.push_back(32'(i));
            qa.push_back(8'(i));
        end
        send_frame(qd, qa);
        wait_done(cyc);
        n_tests++;
        if (sum !== 64'd2505 || enn !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_sum: sum=%0d enn=%b, required 2505/0", sum, enn);
        end
        for (int i = 0; i < K; i++) begin
            idx = IDX_W'(i);
            #1;
            n_tests++;
            if (res_data !== m_val[i] || res_addr !== m_addr[i] || res_data < 32'd246) begin
                n_fail++;
                $display("FAIL ramp_slot[%0d]: data=%0d addr=%0d, required %0d/%0d",
                         i, res_data, res_addr, m_val[i], m_addr[i]);
            end
        end
        for (int i = K; i < (1 << IDX_W); i++) begin
            idx = IDX_W'(i);
            #1;
            n_tests++;
            if (res_data !== '0 || res_addr !== '0) begin
                n_fail++;
                $display("FAIL idx_out_of_range[%0d]: data=%0d addr=%0d, required 0/0", i, res_data, res_addr);
            end
        end
    endtask

    task automatic test_ties();
        logic [31:0] qd[$];
        logic [7:0]  qa[$];
        int cyc;
        model_clear();
        thresh = 64'd7000;
        for (int i = 0; i < 20; i++) begin
            qd.push_back(i == 5 ? 32'd1001 : 32'd1000);
            qa.push_back(8'(i));
        end
        send_frame(qd, qa);
        wait_done(cyc);
        n_tests++;
        if (sum !== 64'd10001 || enn !== 1'b1) begin
            n_fail++;
            $display("FAIL ties_sum: sum=%0d enn=%b, required 10001/1", sum, enn);
        end
        for (int i = 0; i < K; i++) begin
            idx = IDX_W'(i);
            #1;
            n_tests++;
            if (res_data !== m_val[i] || res_addr !== m_addr[i]) begin
                n_fail++;
                $display("FAIL ties_slot[%0d]: data=%0d addr=%0d, required %0d/%0d",
                         i, res_data, res_addr, m_val[i], m_addr[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qd[$];
        logic [7:0]  qa[$];
        int cyc;
        model_clear();
        thresh = 64'd20000;
        for (int i = 0; i < 8; i++) begin
            qd.push_back($urandom_range(1, 5000));
            qa.push_back(8'($urandom));
        end
        send_frame(qd, qa);
        step();
        for (int b = 0; b < 3; b++) begin
            vld  = 1'b1;
            data = 32'hFFFF_FF00 + 32'(b);
            addr = 8'(200 + b);
            #1;
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_busy[%0d]: busy=%b, required 1", b, busy);
            end
            step();
            n_tests++;
            if (drop !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_drop[%0d]: drop=%b, required 1", b, drop);
            end
        end
        vld  = 1'b0;
        data = '0;
        addr = '0;
        step();
        n_tests++;
        if (drop !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drop_clear: drop=%b, required 0", drop);
        end
        wait_done(cyc);
        n_tests++;
        if (sum !== model_sum() || enn !== (model_sum() >= thresh)) begin
            n_fail++;
            $display("FAIL b2b_sum: sum=%0d enn=%b, required %0d/%b", sum, enn, model_sum(), model_sum() >= thresh);
        end
        for (int i = 0; i < K; i++) begin
            idx = IDX_W'(i);
            #1;
            n_tests++;
            if (res_data !== m_val[i] || res_addr !== m_addr[i]) begin
                n_fail++;
                $display("FAIL b2b_slot[%0d]: data=%0d addr=%0d, required %0d/%0d",
                         i, res_data, res_addr, m_val[i], m_addr[i]);
            end
        end
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_rst_in_sum();
        logic [31:0] qd[$];
        logic [7:0]  qa[$];
        bit seen = 0;
        model_clear();
        thresh = 64'd1;
        for (int i = 0; i < 5; i++) begin
            qd.push_back($urandom_range(100, 9000));
            qa.push_back(8'(i + 1));
        end
        send_frame(qd, qa);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        n_tests++;
        if (sum !== '0 || enn !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_sum_state: sum=%0d enn=%b done=%b busy=%b, required 0", sum, enn, done, busy);
        end
        for (int c = 0; c < K + 5; c++) begin
            step();
            if (done === 1'b1) seen = 1;
        end
        n_tests++;
        if (seen || sum !== '0) begin
            n_fail++;
            $display("FAIL rst_sum_no_done: done_seen=%0d sum=%0d, required 0/0", seen, sum);
        end
    endtask

    task automatic test_single_beat();
        logic [31:0] qd[$];
        logic [7:0]  qa[$];
        int cyc;
        model_clear();
        thresh = 64'd7000;
        qd.push_back(32'd9000);
        qa.push_back(8'($urandom));
        send_frame(qd, qa);
        wait_done(cyc);
        n_tests++;
        if (cyc !== K + 1) begin
            n_fail++;
            $display("FAIL single_latency: done after %0d edges, required %0d", cyc, K + 1);
        end
        n_tests++;
        if (sum !== 64'd9000 || enn !== 1'b1) begin
            n_fail++;
            $display("FAIL single_sum: sum=%0d enn=%b, required 9000/1", sum, enn);
        end
        for (int i = 0; i < K; i++) begin
            idx = IDX_W'(i);
            #1;
            n_tests++;
            if (res_data !== (i == 0 ? 32'd9000 : 32'd0) || res_addr !== m_addr[i]) begin
                n_fail++;
                $display("FAIL single_slot[%0d]: data=%0d addr=%0d, required %0d/%0d",
                         i, res_data, res_addr, (i == 0 ? 9000 : 0), m_addr[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [SUM_W-1:0] prev_sum;
        logic             prev_enn;
        int cyc;
        prev_sum = sum;
        prev_enn = enn;
        for (int f = 0; f < 12; f++) begin
            logic [31:0] qd[$];
            logic [7:0]  qa[$];
            int len = $urandom_range(1, 40);
            model_clear();
            thresh = SUM_W'($urandom_range(0, 2000));
            for (int i = 0; i < len; i++) begin
                qd.push_back((f % 2 == 0) ? $urandom_range(0, 200) : $urandom_range(0, 8));
                qa.push_back(8'($urandom));
            end
            send_frame(qd, qa);
            n_tests++;
            if (sum !== prev_sum || enn !== prev_enn) begin
                n_fail++;
                $display("FAIL rand_hold[%0d]: sum=%0d enn=%b, required %0d/%b", f, sum, enn, prev_sum, prev_enn);
            end
            wait_done(cyc);
            n_tests++;
            if (sum !== model_sum() || enn !== (model_sum() >= thresh)) begin
                n_fail++;
                $display("FAIL rand_sum[%0d]: sum=%0d enn=%b, required %0d/%b",
                         f, sum, enn, model_sum(), model_sum() >= thresh);
            end
            for (int i = 0; i < K; i++) begin
                idx = IDX_W'(i);
                #1;
                n_tests++;
                if (res_data !== m_val[i] || res_addr !== m_addr[i]) begin
                    n_fail++;
                    $display("FAIL rand_slot[%0d][%0d]: data=%0d addr=%0d, required %0d/%0d",
                             f, i, res_data, res_addr, m_val[i], m_addr[i]);
                end
            end
            prev_sum = model_sum();
            prev_enn = (model_sum() >= thresh);
        end
    endtask

    task automatic test_sum_width();
        logic [SUM34-1:0] exp;
        int cyc = 0;
`ifdef HISTO_TOPK_SAT_EN
        exp = {SUM34{1'b1}};
`else
        exp = SUM34'(64'd10 * (64'd1 << 31));
`endif
        thresh34 = '0;
        for (int i = 0; i < 10; i++) begin
            vld34  = 1'b1;
            data34 = 32'h8000_0000;
            addr34 = 8'(i);
            step();
        end
        vld34  = 1'b0;
        data34 = '0;
        step();
        while (done34 !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        n_tests++;
        if (done34 !== 1'b1 || sum34 !== exp || enn34 !== 1'b1) begin
            n_fail++;
            $display("FAIL sum34: done=%b sum=%0h enn=%b, required 1/%0h/1", done34, sum34, enn34, exp);
        end
        for (int i = 0; i < K; i++) begin
            idx34 = IDX_W'(i);
            #1;
            n_tests++;
            if (res_data34 !== 32'h8000_0000 || res_addr34 !== 8'(i)) begin
                n_fail++;
                $display("FAIL sum34_slot[%0d]: data=%0h addr=%0d, required 80000000/%0d",
                         i, res_data34, res_addr34, i);
            end
        end
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; data = '0; addr = '0; thresh = '0; idx = '0;
        vld34 = 1'b0; data34 = '0; addr34 = '0; thresh34 = '0; idx34 = '0;
        model_clear();
        test_reset();
        test_ramp();
        test_ties();
        test_back_to_back();
        test_rst_in_sum();
        test_single_beat();
        test_random();
        test_sum_width();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
